// File: rtl/tbu_lifo_if.sv
// rtl/tbu_lifo_if.sv - traceback-side write strobes and decoder-side bit stream for tbu_lifo
interface tbu_lifo_if;
  logic       enable;
  logic       d_in;
  logic       wr_en;
  logic       d_out;
  logic       d_out_valid;
  logic       d_out_ready;
  logic [1:0] bank_full;
  logic       overflow;

  modport master (
    output enable, d_in, wr_en, d_out_ready,
    input  d_out, d_out_valid, bank_full, overflow
  );

  modport slave (
    input  enable, d_in, wr_en, d_out_ready,
    output d_out, d_out_valid, bank_full, overflow
  );
endinterface

// File: rtl/tbu_lifo.sv
// rtl/tbu_lifo.sv - ping-pong LIFO that reverses newest-first traceback bursts into chronological order
module tbu_lifo #(
  parameter int DEPTH = 64
) (
  input  logic       clk,
  input  logic       rst,
  tbu_lifo_if.slave  io
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] TOP = AW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;

  logic [DEPTH-1:0] mem_q [2];
  logic [CW-1:0]    len_q [2];
  logic [CW-1:0]    count_q;
  logic [AW-1:0]    raddr_q;
  logic [1:0]       bank_full_q;
  logic [1:0]       bank_full_d;
  state_t           state_q;
  logic             wbank_q;
  logic             rbank_q;
  logic             in_burst_q;
  logic             drop_q;
  logic             overflow_q;
  logic             d_out_q;
  logic             d_out_valid_q;
  logic             last_q;

  logic          wr_act;
  logic          first_bit;
  logic          take_bit;
  logic          close_full;
  logic          close_len;
  logic          drain_done;
  logic [CW-1:0] count_inc;
  logic [CW-1:0] raddr_start;
  logic [AW-1:0] waddr;

  assign wr_act      = io.wr_en & io.enable;
  assign first_bit   = wr_act & ~in_burst_q;
  assign take_bit    = wr_act & ~drop_q & (in_burst_q | ~bank_full_q[wbank_q]);
  assign count_inc   = count_q + CW'(1);
  assign waddr       = TOP - count_q[AW-1:0];
  assign close_full  = take_bit & (count_inc == CW'(DEPTH));
  assign close_len   = ~wr_act & in_burst_q & ~drop_q & (count_q != '0);
  assign drain_done  = (state_q == STREAM) & d_out_valid_q & io.d_out_ready & last_q;
  assign raddr_start = CW'(DEPTH) - len_q[rbank_q];

  // Write side closes wbank while read side frees rbank; they are never the same bank.
  always_comb begin
    bank_full_d = bank_full_q;
    if (drain_done) begin
      bank_full_d[rbank_q] = 1'b0;
    end
    if (close_full || close_len) begin
      bank_full_d[wbank_q] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q[0]      <= '0;
      len_q[1]      <= '0;
      count_q       <= '0;
      raddr_q       <= '0;
      bank_full_q   <= 2'b00;
      state_q       <= IDLE;
      wbank_q       <= 1'b0;
      rbank_q       <= 1'b0;
      in_burst_q    <= 1'b0;
      drop_q        <= 1'b0;
      overflow_q    <= 1'b0;
      d_out_q       <= 1'b0;
      d_out_valid_q <= 1'b0;
      last_q        <= 1'b0;
    end else begin
      bank_full_q <= bank_full_d;

      if (take_bit) begin
        mem_q[wbank_q][waddr] <= io.d_in;
      end

      // drop_q marks a burst whose remaining bits are discarded (bank full at start, or bank filled)
      if (wr_act) begin
        in_burst_q <= 1'b1;
        if (first_bit && bank_full_q[wbank_q]) begin
          drop_q     <= 1'b1;
          overflow_q <= 1'b1;
        end else if (drop_q) begin
          overflow_q <= 1'b1;
        end else if (close_full) begin
          len_q[wbank_q] <= count_inc;
          wbank_q        <= ~wbank_q;
          count_q        <= '0;
          drop_q         <= 1'b1;
        end else begin
          count_q <= count_inc;
        end
      end else begin
        if (close_len) begin
          len_q[wbank_q] <= count_q;
          wbank_q        <= ~wbank_q;
        end
        in_burst_q <= 1'b0;
        drop_q     <= 1'b0;
        count_q    <= '0;
      end

      case (state_q)
        IDLE: begin
          if (bank_full_q[rbank_q]) begin
            raddr_q <= raddr_start[AW-1:0];
            state_q <= LOAD;
          end
        end
        LOAD: begin
          d_out_q       <= mem_q[rbank_q][raddr_q];
          d_out_valid_q <= 1'b1;
          last_q        <= (raddr_q == TOP);
          raddr_q       <= raddr_q + AW'(1);
          state_q       <= STREAM;
        end
        STREAM: begin
          if (d_out_valid_q && io.d_out_ready) begin
            if (last_q) begin
              d_out_valid_q <= 1'b0;
              rbank_q       <= ~rbank_q;
              state_q       <= IDLE;
            end else begin
              d_out_q <= mem_q[rbank_q][raddr_q];
              last_q  <= (raddr_q == TOP);
              raddr_q <= raddr_q + AW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io.d_out       = d_out_q;
  assign io.d_out_valid = d_out_valid_q;
  assign io.bank_full   = bank_full_q;
  assign io.overflow    = overflow_q;
endmodule
